// File: rtl/crc_hash_arbiter_pkg.sv
// crc_arb_pkg: shared types and widths for the CRC32 hash arbiter slice.
//   arb_state_e : arbiter FSM states
//   tag_t       : in-flight tag {valid, id}; id sized for the largest
//                 supported requester count (16), top trims to ID_W
package crc_arb_pkg;

  localparam int KEY_W    = 64;
  localparam int HASH_W   = 32;
  localparam int MAX_ID_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/crc_hash_arbiter_if.sv
// crc_hash_arbiter_if: requester bus, engine link and response bus.
//   req_valid/req_data/req_ready : per-requester key handshake
//   crc_data/crc_datavalid       : key strobe into the CRC32 engine
//   crc_checksum/crc_crcvalid    : engine result
//   rsp_valid/rsp_id/rsp_hash    : tagged result, single-cycle pulse
// slave  = arbiter side, master = requesters + engine side.
interface crc_hash_arbiter_if
  import crc_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) ();

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][KEY_W-1:0]  req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic [KEY_W-1:0]               crc_data;
  logic                           crc_datavalid;
  logic [HASH_W-1:0]              crc_checksum;
  logic                           crc_crcvalid;
  logic                           rsp_valid;
  logic [ID_W-1:0]                rsp_id;
  logic [HASH_W-1:0]              rsp_hash;

  modport slave (
    input  req_valid, req_data, crc_checksum, crc_crcvalid,
    output req_ready, crc_data, crc_datavalid, rsp_valid, rsp_id, rsp_hash
  );

  modport master (
    output req_valid, req_data, crc_checksum, crc_crcvalid,
    input  req_ready, crc_data, crc_datavalid, rsp_valid, rsp_id, rsp_hash
  );

endinterface

// File: rtl/crc_hash_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick.
//   req     : request vector
//   ptr     : highest-priority index this cycle
//   gnt     : one-hot grant
//   gnt_idx : encoded grant index (0 when no grant)
//   any_gnt : some request was granted
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               any_gnt
);

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    // Walk from the farthest offset down so the closest request to ptr
    // is the last writer and wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = ID_W'(idx);
        any_gnt  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/crc_hash_arbiter.sv
// crc_hash_arbiter: shares one CRC32 engine among NUM_REQ requesters.
// Round-robin issues at most one key per cycle while in RUN, tracks the
// requester id of each key across the engine latency, and returns each
// hash tagged with its requester.
//   clk, reset_n : clock, async active-low reset
//   en           : arbitration enable (IDLE->RUN, RUN->DRAIN)
//   bus          : crc_hash_arbiter_if.slave (requests, engine, responses)
//   idle         : FSM is in IDLE
//   err          : sticky, engine result valid disagreed with tag valid
// Optional (CRC_ARB_STATS_EN): per-requester grant/stall counters read
// through stat_sel -> stat_grants/stat_stalls (1-cycle), cleared by stat_clr.
module crc_hash_arbiter
  import crc_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CRC_LAT = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  crc_hash_arbiter_if.slave   bus,
  output logic                idle,
  output logic                err
`ifdef CRC_ARB_STATS_EN
  ,
  input  logic [ID_W-1:0]     stat_sel,
  input  logic                stat_clr,
  output logic [31:0]         stat_grants,
  output logic [15:0]         stat_stalls
`endif
);

  arb_state_e               state, state_nxt;
  logic [ID_W-1:0]          rr_ptr;
  tag_t [CRC_LAT-1:0]       tag_pipe;
  tag_t                     tag_in;
  tag_t                     tag_tail;
  logic                     pipe_busy;

  logic [NUM_REQ-1:0]       req_gated;
  logic [NUM_REQ-1:0]       gnt;
  logic [ID_W-1:0]          gnt_idx;
  logic                     any_gnt;
  logic                     unused_tag_bits;

  // ---------------- grant path (combinational) ----------------
  assign req_gated = (state == RUN) ? bus.req_valid : '0;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req     (req_gated),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  assign bus.req_ready     = gnt;
  assign bus.crc_datavalid = any_gnt;
  assign bus.crc_data      = any_gnt ? bus.req_data[gnt_idx] : '0;

  // ---------------- FSM ----------------
  // The tail stage retires against this cycle's crcvalid, so draining is
  // done once nothing sits in the stages ahead of it.
  always_comb begin
    pipe_busy = 1'b0;
    for (int s = 0; s < CRC_LAT - 1; s++) pipe_busy = pipe_busy | tag_pipe[s].valid;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (en)         state_nxt = RUN;
      RUN:     if (!en)        state_nxt = DRAIN;
      DRAIN:   if (!pipe_busy) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  assign idle = (state == IDLE);

  // ---------------- round-robin pointer ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (any_gnt) begin
      rr_ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  // ---------------- tag pipeline ----------------
  assign tag_in   = '{valid: any_gnt, id: MAX_ID_W'(gnt_idx)};
  assign tag_tail = tag_pipe[CRC_LAT-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int s = 1; s < CRC_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  // id is sized for 16 requesters; upper bits are zero for smaller configs
  assign unused_tag_bits = ^tag_tail.id;

  // ---------------- response + error ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_hash  <= '0;
      err           <= 1'b0;
    end else begin
      bus.rsp_valid <= bus.crc_crcvalid;
      if (bus.crc_crcvalid) begin
        bus.rsp_id   <= tag_tail.id[ID_W-1:0];
        bus.rsp_hash <= bus.crc_checksum;
      end
      if (bus.crc_crcvalid != tag_tail.valid) err <= 1'b1;
    end
  end

`ifdef CRC_ARB_STATS_EN
  // ---------------- statistics ----------------
  logic [31:0] grant_cnt [NUM_REQ];
  logic [15:0] stall_cnt [NUM_REQ];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_cnt[i] <= '0;
        stall_cnt[i] <= '0;
      end
    end else if (stat_clr) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_cnt[i] <= '0;
        stall_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && grant_cnt[i] != '1)
          grant_cnt[i] <= grant_cnt[i] + 1'b1;
        if (state == RUN && bus.req_valid[i] && !gnt[i] && stall_cnt[i] != '1)
          stall_cnt[i] <= stall_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else if (int'(stat_sel) < NUM_REQ) begin
      stat_grants <= grant_cnt[stat_sel];
      stat_stalls <= stall_cnt[stat_sel];
    end else begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_crc_hash_arbiter.sv
// tb_crc_hash_arbiter: directed scenarios plus a randomized phase, all
// checked per cycle against a transaction-level model (priority search,
// expected-response queue keyed by due cycle). Engine is a 1-cycle stub
// with checksum = data[63:32] ^ data[31:0].
module tb_crc_hash_arbiter;
  import crc_arb_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int LAT = 1;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

  logic clk = 1'b0;
  logic reset_n;
  logic en;
  logic idle, err;
`ifdef CRC_ARB_STATS_EN
  logic [IDW-1:0] stat_sel;
  logic           stat_clr;
  logic [31:0]    stat_grants;
  logic [15:0]    stat_stalls;
`endif

  always #5 clk = ~clk;

  crc_hash_arbiter_if #(.NUM_REQ(N), .ID_W(IDW)) bus ();

  crc_hash_arbiter #(.NUM_REQ(N), .ID_W(IDW), .CRC_LAT(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .bus     (bus),
    .idle    (idle),
    .err     (err)
`ifdef CRC_ARB_STATS_EN
    ,
    .stat_sel    (stat_sel),
    .stat_clr    (stat_clr),
    .stat_grants (stat_grants),
    .stat_stalls (stat_stalls)
`endif
  );

  // engine stub (latency 1), deliberately not reset
  logic        stub_v = 1'b0;
  logic [63:0] stub_d = '0;
  always @(posedge clk) begin
    stub_v <= bus.crc_datavalid;
    stub_d <= bus.crc_data;
  end
  assign bus.crc_crcvalid = stub_v;
  assign bus.crc_checksum = stub_d[63:32] ^ stub_d[31:0];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    int          id;
    logic [31:0] h;
  } rsp_t;

  rsp_t        m_q[$];
  int          m_mode, m_ptr, m_last, cyc;
  logic        m_rsp_v;
  int          m_rsp_id;
  logic [31:0] m_rsp_h;
  logic        chk_on = 1'b0;

  task automatic m_reset();
    m_q.delete();
    m_mode   = M_IDLE;
    m_ptr    = 0;
    m_last   = -100;
    cyc      = 0;
    m_rsp_v  = 1'b0;
    m_rsp_id = 0;
    m_rsp_h  = '0;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin : model
      int          g;
      logic [3:0]  exp_rdy;
      logic [63:0] exp_d;
      rsp_t        r;
      g = -1;
      if (m_mode == M_RUN)
        for (int k = 0; k < N; k++)
          if (g < 0 && bus.req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      exp_rdy = '0;
      exp_d   = '0;
      if (g >= 0) begin
        exp_rdy[g] = 1'b1;
        exp_d      = bus.req_data[g];
      end
      chk("ready", 64'(bus.req_ready), 64'(exp_rdy));
      chk("datavalid", 64'(bus.crc_datavalid), 64'(g >= 0));
      chk("crc_data", bus.crc_data, exp_d);
      chk("idle", 64'(idle), 64'(m_mode == M_IDLE));
      chk("err", 64'(err), 64'd0);
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_rsp_v));
      chk("rsp_id", 64'(bus.rsp_id), 64'(m_rsp_id));
      chk("rsp_hash", 64'(bus.rsp_hash), 64'(m_rsp_h));
      // advance to next cycle
      m_rsp_v = 1'b0;
      if (m_q.size() > 0 && m_q[0].due == cyc + 1) begin
        r = m_q.pop_front();
        m_rsp_v  = 1'b1;
        m_rsp_id = r.id;
        m_rsp_h  = r.h;
      end
      if (g >= 0) begin
        m_q.push_back('{due: cyc + LAT + 1, id: g, h: exp_d[63:32] ^ exp_d[31:0]});
        m_ptr  = (g + 1) % N;
        m_last = cyc;
      end
      case (m_mode)
        M_IDLE:  if (en) m_mode = M_RUN;
        M_RUN:   if (!en) m_mode = M_DRAIN;
        default: if (cyc >= m_last + LAT) m_mode = M_IDLE;
      endcase
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit check_vals);
    chk_on        = 1'b0;
    reset_n       = 1'b0;
    en            = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
`ifdef CRC_ARB_STATS_EN
    stat_sel = '0;
    stat_clr = 1'b0;
`endif
    repeat (3) step();
    if (check_vals) begin
      @(negedge clk);
      chk("rst_idle", 64'(idle), 64'd1);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
      chk("rst_rsp_hash", 64'(bus.rsp_hash), 64'd0);
      chk("rst_rr_ptr", 64'(dut.rr_ptr), 64'd0);
      step();
    end
    reset_n = 1'b1;
    m_reset();
    chk_on = 1'b1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) bus.req_data[i] = {$urandom, $urandom};
  endtask

  initial begin
    do_reset(1'b1);

    // 1: single request
    step(); en = 1'b1;
    step(); bus.req_valid = 4'b0100; bus.req_data[2] = 64'h0000_0001_0000_0003;
    @(negedge clk); chk("s1_ready", 64'(bus.req_ready), 64'h4);
    step(); bus.req_valid = '0;
    step();
    @(negedge clk);
    chk("s1_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("s1_rsp_id", 64'(bus.rsp_id), 64'd2);
    chk("s1_rsp_hash", 64'(bus.rsp_hash), 64'h2);

    // 2: all four valid for 8 cycles
    do_reset(1'b0);
    step(); en = 1'b1;
    step(); bus.req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      rand_data();
      @(negedge clk); chk("s2_order", 64'(bus.req_ready), 64'(1 << (k % 4)));
      step();
    end
    bus.req_valid = '0;
    chk("s2_rr_ptr", 64'(dut.rr_ptr), 64'd0);

    // 3: fairness and wrap from rr_ptr=3
    bus.req_valid = 4'b0100; rand_data();
    step(); bus.req_valid = 4'b1001; rand_data();
    chk("s3_ptr3", 64'(dut.rr_ptr), 64'd3);
    @(negedge clk); chk("s3_g3a", 64'(bus.req_ready), 64'h8);
    step(); rand_data();
    @(negedge clk); chk("s3_g0", 64'(bus.req_ready), 64'h1);
    step(); rand_data();
    @(negedge clk); chk("s3_g3b", 64'(bus.req_ready), 64'h8);
    step(); bus.req_valid = '0;
    repeat (3) step();

    // 4: drain; en re-raised during DRAIN is deferred to IDLE
    bus.req_valid = 4'b0011; rand_data();               // N
    step(); en = 1'b0;                                  // N+1
    step(); en = 1'b1;                                  // N+2 (DRAIN)
    @(negedge clk); chk("s4_no_grant", 64'(bus.req_ready), 64'd0);
    step();                                             // N+3
    @(negedge clk);
    chk("s4_idle", 64'(idle), 64'd1);
    chk("s4_err", 64'(err), 64'd0);
    step(); bus.req_valid = '0;
    repeat (4) step();

    // random phase
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 9) != 0);
      bus.req_valid = 4'($urandom);
      rand_data();
      step();
    end
    en = 1'b0; bus.req_valid = '0;
    repeat (5) step();

    // 5: reset mid-flight; stub's late crcvalid trips err
    do_reset(1'b0);
    step(); en = 1'b1;
    step(); bus.req_valid = 4'b0010; rand_data();       // grant
    @(posedge clk); chk_on = 1'b0;
    #2 reset_n = 1'b0; bus.req_valid = '0;
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("s5_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("s5_idle", 64'(idle), 64'd1);
    chk("s5_rr_ptr", 64'(dut.rr_ptr), 64'd0);
    step();
    @(negedge clk); chk("s5_err", 64'(err), 64'd1);

`ifdef CRC_ARB_STATS_EN
    // 6: statistics
    do_reset(1'b0);
    step(); en = 1'b1;
    step(); bus.req_valid = 4'b0001; rand_data();      // moves rr_ptr to 1
    step(); bus.req_valid = 4'b0011;
    repeat (5) begin rand_data(); step(); end
    bus.req_valid = 4'b0001; stat_sel = 2'd1;
    step(); bus.req_valid = '0;
    @(negedge clk);
    chk("s6_grants", 64'(stat_grants), 64'd3);
    chk("s6_stalls", 64'(stat_stalls), 64'd2);
    step(); stat_clr = 1'b1;
    step(); stat_clr = 1'b0;
    step();
    @(negedge clk);
    chk("s6_grants_clr", 64'(stat_grants), 64'd0);
    chk("s6_stalls_clr", 64'(stat_stalls), 64'd0);
`endif

    chk_on = 1'b0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
